intersection_sequencer: RTL
===========================

// Module: intersection_sequencer
// PURPOSE
//  Sequences the shared 4-bit countdown timer and drives the NS/EW/pedestrian lights of one intersection.
//  Round-robin scheduler across three requesters (NS cars, EW cars, pedestrians), with green extension and all-red clearance.
//  Sits between the request switches/debounced buttons and the timer. Drives the timer's en/load/init and reads its out.
// PARAMETERS
//  TW        4  width of timer_init/timer_out
//  GREEN_T   5  green duration load value (NS and EW)
//  YELLOW_T  2  yellow duration load value
//  ALLRED_T  1  all-red clearance load value
//  WALK_T    4  pedestrian walk load value
// PORTS
//  clk         in   1   system clock (1 Hz divided clock in the system)
//  rstb        in   1   asynchronous reset, active-low
//  car_ns      in   1   NS car request (level)
//  car_ew      in   1   EW car request (level)
//  ped         in   1   pedestrian request (level or 1-cycle pulse; latched internally)
//  timer_out   in   TW  current timer count
//  timer_en    out  1   timer count enable
//  timer_load  out  1   timer load strobe, 1-cycle pulse
//  timer_init  out  TW  timer load value
//  light_ns    out  3   NS lights {R,Y,G}, one-hot
//  light_ew    out  3   EW lights {R,Y,G}, one-hot
//  light_ped   out  2   pedestrian lights {DONT_WALK,WALK}, one-hot
// BEHAVIOUR
//  - Timer contract: load has priority; timer_out=timer_init the cycle after the load edge. Otherwise it decrements by 1 per enabled edge and holds at 0.
//  - All outputs are registered. While rstb=0: state=INIT, light_ns=light_ew=3'b100, light_ped=2'b10,
//    timer_en=0, timer_load=0, timer_init=0, ped_pending=0, rr_last=PED (so NS is searched first).
//  - States: INIT, ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK.
//  - First edge after rstb release: INIT->ALL_RED; timer_en=1 from then on.
//  - Every state entry, including re-entry for green extension, drives timer_load=1 and timer_init=<state duration>
//    for exactly the first cycle in the state.
//  - Expiry = timer_out==0 && timer_load==0. The load cycle never counts as expiry (stale 0 is ignored).
//    Dwell per state visit = DUR+2 cycles. Defaults: green 7, yellow 4, all-red 3, walk 6.
//  - Transitions on expiry:
//    NS_GREEN->NS_YELLOW->ALL_RED and EW_GREEN->EW_YELLOW->ALL_RED; PED_WALK->ALL_RED.
//    ALL_RED->grant. Grant = first asserted of {car_ns, car_ew, ped_pending}, searched round-robin starting after rr_last.
//    If none is asserted, grant NS (rest phase). rr_last is updated to the granted requester.
//  - Green extension: at NS_GREEN expiry, if car_ew==0 and ped_pending==0, re-enter NS_GREEN (reload, lights unchanged).
//    EW_GREEN is symmetric, using car_ns. Yellow, all-red and walk are never extended.
//  - ped_pending: set on any edge with ped=1; cleared on the edge entering PED_WALK (clear wins).
//    If ped is still high, it re-sets on the next edge.
//  - Lights: the green phase shows G on its road; the yellow phase shows Y; the other road shows R.
//    ALL_RED/INIT show R on both roads. PED_WALK shows R on both roads and light_ped=2'b01; light_ped=2'b10 everywhere else.
//  - Invariant: never green/yellow on both roads, and never WALK with either road non-red.
//  - rstb asserted mid-phase: outputs go to reset values immediately (asynchronously). The sequence restarts via INIT->ALL_RED.
// TESTING
//  T1 reset: rstb=0 -> lights 100/100/10, en=0, load=0. Release, no requests: ALL_RED with load=1, init=1;
//     NS_GREEN after 3 cycles with load=1, init=5.
//  T2 NS green with car_ew=1: NS 001 for 7 cycles, 010 for 4, all-red for 3, then EW 001 with init=5.
//  T3 car_ns=car_ew=ped=1 held: phase grant order NS,EW,PED,NS,EW,PED. light_ped=01 for exactly 6 cycles per PED phase.
//  T4 only car_ns=1: NS_GREEN extends indefinitely. timer_load pulses every 7 cycles with init=5; light_ns stays 001.
//  T5 1-cycle ped pulse during EW_GREEN: ped_pending=1. At expiry EW goes yellow, then all-red, then PED_WALK (WALK 6 cycles),
//     then all-red, then NS.
//  T6 rstb=0 pulse mid NS_YELLOW: same cycle -> 100/100/10, en=0. After release, INIT->ALL_RED load=1, init=1.
//     Check the safety invariant on every cycle of all tests.

Source files
------------

// File: rtl/intersection_sequencer.sv
// intersection_sequencer: round-robin NS/EW/pedestrian light sequencer driving a shared countdown timer
// Ports:
//    clk, rstb               clock, asynchronous active-low reset
//    car_ns, car_ew, ped     requests (ped may be a 1-cycle pulse, it is latched)
//    timer_out               current count of the external timer
//    timer_en/load/init      timer control, all registered
//    light_ns, light_ew      {R,Y,G} one-hot
//    light_ped               {DONT_WALK,WALK} one-hot
module intersection_sequencer #(
   parameter int TW       = 4,
   parameter int GREEN_T  = 5,
   parameter int YELLOW_T = 2,
   parameter int ALLRED_T = 1,
   parameter int WALK_T   = 4
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic          car_ns,
   input  logic          car_ew,
   input  logic          ped,
   input  logic [TW-1:0] timer_out,
   output logic          timer_en,
   output logic          timer_load,
   output logic [TW-1:0] timer_init,
   output logic [2:0]    light_ns,
   output logic [2:0]    light_ew,
   output logic [1:0]    light_ped
);
   typedef enum logic [2:0] {INIT, ALL_RED, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, PED_WALK} state_t;
   typedef enum logic [1:0] {RR_NS, RR_EW, RR_PED} rr_t;
   localparam logic [TW-1:0] G_T  = TW'(GREEN_T);
   localparam logic [TW-1:0] Y_T  = TW'(YELLOW_T);
   localparam logic [TW-1:0] AR_T = TW'(ALLRED_T);
   localparam logic [TW-1:0] W_T  = TW'(WALK_T);
   state_t        state_q, state_d;
   rr_t           rr_q, rr_d, grant;
   logic          ped_q, ped_d, expiry, enter;
   logic [TW-1:0] init_d;
   logic [2:0]    ns_d, ew_d;
   logic [1:0]    ped_light_d;
   // a zero seen during the load cycle is the previous phase's leftover count
   assign expiry = (timer_out == '0) && !timer_load;
   // search starts just after the last granted requester; nothing pending rests on NS
   assign grant = (rr_q == RR_NS) ? (car_ew ? RR_EW : ped_q ? RR_PED : RR_NS) :
                  (rr_q == RR_EW) ? (ped_q ? RR_PED : car_ns ? RR_NS : car_ew ? RR_EW : RR_NS) :
                                    (car_ns ? RR_NS : car_ew ? RR_EW : ped_q ? RR_PED : RR_NS);
   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:      state_d = ALL_RED;
         ALL_RED:   state_d = !expiry ? ALL_RED : grant == RR_NS ? NS_GREEN : grant == RR_EW ? EW_GREEN : PED_WALK;
         NS_GREEN:  state_d = (expiry && (car_ew || ped_q)) ? NS_YELLOW : NS_GREEN;
         EW_GREEN:  state_d = (expiry && (car_ns || ped_q)) ? EW_YELLOW : EW_GREEN;
         default:   state_d = expiry ? ALL_RED : state_q;
      endcase
   end
   // an expiry that keeps the state is a green extension, which also reloads
   assign enter       = (state_d != state_q) || expiry;
   assign rr_d        = (state_q == ALL_RED && expiry) ? grant : rr_q;
   assign ped_d       = (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : (ped_q | ped);
   assign init_d      = (state_d == ALL_RED) ? AR_T :
                        (state_d == NS_GREEN || state_d == EW_GREEN) ? G_T :
                        (state_d == NS_YELLOW || state_d == EW_YELLOW) ? Y_T :
                        (state_d == PED_WALK) ? W_T : '0;
   assign ns_d        = (state_d == NS_GREEN) ? 3'b001 : (state_d == NS_YELLOW) ? 3'b010 : 3'b100;
   assign ew_d        = (state_d == EW_GREEN) ? 3'b001 : (state_d == EW_YELLOW) ? 3'b010 : 3'b100;
   assign ped_light_d = (state_d == PED_WALK) ? 2'b01 : 2'b10;
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q    <= INIT;
         rr_q       <= RR_PED;
         ped_q      <= 1'b0;
         timer_en   <= 1'b0;
         timer_load <= 1'b0;
         timer_init <= '0;
         light_ns   <= 3'b100;
         light_ew   <= 3'b100;
         light_ped  <= 2'b10;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         ped_q      <= ped_d;
         timer_en   <= 1'b1;
         timer_load <= enter;
         timer_init <= init_d;
         light_ns   <= ns_d;
         light_ew   <= ew_d;
         light_ped  <= ped_light_d;
      end
   end
endmodule
